// File: rtl/fetch_if.sv
// fetch_if: hazard/redirect controls, instruction-memory handshake and IF/ID outputs of the fetch stage
interface fetch_if #(parameter int DATA_WIDTH = 32, parameter int INSTR_WIDTH = 32);
  logic                   stall_f_i;
  logic                   redirect_i;
  logic [DATA_WIDTH-1:0]  redirect_pc_i;
  logic                   imem_req_o;
  logic [DATA_WIDTH-1:0]  imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic [INSTR_WIDTH-1:0] instr_f_o;
  logic [DATA_WIDTH-1:0]  pc_f_o;
  logic [DATA_WIDTH-1:0]  pc_plus_4_f_o;
  logic                   valid_f_o;
  modport master (
    input  stall_f_i, redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, instr_f_o, pc_f_o, pc_plus_4_f_o, valid_f_o
  );
  modport slave (
    output stall_f_i, redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, instr_f_o, pc_f_o, pc_plus_4_f_o, valid_f_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-outstanding imem fetches and holding the result for IF/ID
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master f
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic        kill_q, kill_d, out_valid_q, out_valid_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (f.redirect_i) begin
      // a fetch still in flight after the redirect must have its response dropped
      pc_d        = f.redirect_pc_i & ~32'd3;
      out_valid_d = 1'b0;
      state_d     = REQ;
      kill_d      = 1'b0;
      if ((state_q == REQ && f.imem_gnt_i) || (state_q == WAIT && !f.imem_rvalid_i)) begin
        state_d = WAIT;
        kill_d  = 1'b1;
      end
    end else begin
      case (state_q)
        REQ: state_d = f.imem_gnt_i ? WAIT : REQ;
        WAIT: begin
          if (f.imem_rvalid_i && kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (f.imem_rvalid_i) begin
            out_instr_d = f.imem_rdata_i;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          out_valid_d = f.stall_f_i ? out_valid_q : 1'b0;
          state_d     = f.stall_f_i ? HOLD : REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end
  assign f.imem_req_o    = (state_q == REQ);
  assign f.imem_addr_o   = pc_q;
  assign f.valid_f_o     = out_valid_q;
  assign f.instr_f_o     = out_valid_q ? out_instr_q : NOP_INSTR;
  assign f.pc_f_o        = out_pc_q;
  assign f.pc_plus_4_f_o = out_pc_q + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: transaction-level model of the fetch stage checked every cycle, plus directed literal checks
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  fetch_if u_if ();
  fetch_if w_if ();
  fetch_unit u_dut (.clk(clk), .rst(rst), .f(u_if));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) w_dut (.clk(clk), .rst(rst), .f(w_if));
  always #5 clk = ~clk;

  // model: outstanding fetches (with their killed flag), next fetch address, held instruction
  bit          pend[$];
  logic [31:0] m_pc, m_instr, m_opc;
  bit          m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_pc    = 32'h0;
    m_opc   = 32'h0;
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  function automatic bit exp_req();
    return pend.size() == 0 && !m_valid;
  endfunction

  task automatic model_update();
    bit granted;
    if (rst) begin
      model_reset();
      return;
    end
    granted = exp_req() && u_if.imem_gnt_i;
    if (u_if.redirect_i) begin
      m_pc    = {u_if.redirect_pc_i[31:2], 2'b00};
      m_valid = 1'b0;
      if (pend.size() != 0 && u_if.imem_rvalid_i) void'(pend.pop_front());
      foreach (pend[i]) pend[i] = 1'b1;
      if (granted) pend.push_back(1'b1);
    end else if (granted) begin
      pend.push_back(1'b0);
    end else if (pend.size() != 0 && u_if.imem_rvalid_i) begin
      if (!pend.pop_front()) begin
        m_valid = 1'b1;
        m_instr = u_if.imem_rdata_i;
        m_opc   = m_pc;
        m_pc    = m_pc + 32'd4;
      end
    end else if (m_valid && !u_if.stall_f_i) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare();
    chk("req", u_if.imem_req_o, exp_req());
    chk("addr", u_if.imem_addr_o, m_pc);
    chk("valid", u_if.valid_f_o, m_valid);
    chk("instr", u_if.instr_f_o, m_valid ? m_instr : NOP);
    chk("pc_f", u_if.pc_f_o, m_opc);
    chk("pc_plus_4", u_if.pc_plus_4_f_o, m_opc + 32'd4);
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    u_if.stall_f_i = 0; u_if.redirect_i = 0; u_if.redirect_pc_i = 0;
    u_if.imem_gnt_i = 0; u_if.imem_rvalid_i = 0; u_if.imem_rdata_i = 0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    u_if.redirect_i = 1; u_if.redirect_pc_i = t;
    cycle();
    idle();
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
    idle();
    w_if.stall_f_i = 0; w_if.redirect_i = 0; w_if.redirect_pc_i = 0;
    w_if.imem_gnt_i = 0; w_if.imem_rvalid_i = 0; w_if.imem_rdata_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_req", u_if.imem_req_o, 1);
    chk("rst_addr", u_if.imem_addr_o, 32'h0);
    chk("rst_instr", u_if.instr_f_o, NOP);
    chk("rst_pc4", u_if.pc_plus_4_f_o, 32'h4);

    // wrap-around instance
    chk("wrap_rst_pc4", w_if.pc_plus_4_f_o, 32'h0);
    w_if.imem_gnt_i = 1; cycle();
    w_if.imem_gnt_i = 0; w_if.imem_rvalid_i = 1; w_if.imem_rdata_i = 32'h1234_5678; cycle();
    w_if.imem_rvalid_i = 0;
    chk("wrap_valid", w_if.valid_f_o, 1);
    chk("wrap_pc", w_if.pc_f_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_if.pc_plus_4_f_o, 32'h0);
    cycle();
    chk("wrap_req", w_if.imem_req_o, 1);
    chk("wrap_addr", w_if.imem_addr_o, 32'h0);

    // zero-wait stream
    for (int i = 0; i < 3; i++) begin
      chk("zw_req", u_if.imem_req_o, 1);
      chk("zw_addr", u_if.imem_addr_o, 32'(4 * i));
      u_if.imem_gnt_i = 1; cycle();
      u_if.imem_gnt_i = 0; u_if.imem_rvalid_i = 1; u_if.imem_rdata_i = prog[i]; cycle();
      idle();
      chk("zw_valid", u_if.valid_f_o, 1);
      chk("zw_instr", u_if.instr_f_o, prog[i]);
      chk("zw_pc", u_if.pc_f_o, 32'(4 * i));
      chk("zw_pc4", u_if.pc_plus_4_f_o, 32'(4 * i + 4));
      cycle();
    end

    // stall while holding 0x00500093 @0x0
    redirect_to(32'h0);
    u_if.imem_gnt_i = 1; cycle();
    u_if.imem_gnt_i = 0; u_if.imem_rvalid_i = 1; u_if.imem_rdata_i = prog[0]; cycle();
    idle();
    u_if.stall_f_i = 1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", u_if.valid_f_o, 1);
      chk("stall_instr", u_if.instr_f_o, prog[0]);
      chk("stall_req", u_if.imem_req_o, 0);
      cycle();
    end
    u_if.stall_f_i = 0; cycle();
    chk("unstall_req", u_if.imem_req_o, 1);
    chk("unstall_addr", u_if.imem_addr_o, 32'h4);

    // redirect in WAIT, response later
    u_if.imem_gnt_i = 1; cycle(); idle();
    redirect_to(32'h100);
    u_if.imem_rvalid_i = 1; u_if.imem_rdata_i = 32'hDEAD_BEEF; cycle(); idle();
    chk("rw_valid", u_if.valid_f_o, 0);
    chk("rw_req", u_if.imem_req_o, 1);
    chk("rw_addr", u_if.imem_addr_o, 32'h100);
    // redirect and response together
    u_if.imem_gnt_i = 1; cycle(); idle();
    u_if.imem_rvalid_i = 1; u_if.imem_rdata_i = 32'hDEAD_BEEF;
    redirect_to(32'h100);
    chk("rwr_valid", u_if.valid_f_o, 0);
    chk("rwr_req", u_if.imem_req_o, 1);
    chk("rwr_addr", u_if.imem_addr_o, 32'h100);

    // redirect coincident with grant
    redirect_to(32'h8);
    chk("rg_addr8", u_if.imem_addr_o, 32'h8);
    u_if.imem_gnt_i = 1; redirect_to(32'h200);
    chk("rg_req", u_if.imem_req_o, 0);
    u_if.imem_rvalid_i = 1; u_if.imem_rdata_i = 32'h1111_1111; cycle(); idle();
    chk("rg_valid", u_if.valid_f_o, 0);
    chk("rg_addr", u_if.imem_addr_o, 32'h200);

    // alignment
    redirect_to(32'h103);
    chk("align_addr", u_if.imem_addr_o, 32'h100);

    // reset while in WAIT, late response ignored
    u_if.imem_gnt_i = 1; cycle(); idle();
    rst = 1; model_reset(); #1;
    chk("rstw_req", u_if.imem_req_o, 1);
    chk("rstw_valid", u_if.valid_f_o, 0);
    u_if.imem_rvalid_i = 1; u_if.imem_rdata_i = 32'hBAD0_0BAD; cycle();
    rst = 0; cycle(); idle(); cycle();
    chk("rstw_instr", u_if.instr_f_o, NOP);
    chk("rstw_valid2", u_if.valid_f_o, 0);
    chk("rstw_req2", u_if.imem_req_o, 1);
    chk("rstw_addr", u_if.imem_addr_o, 32'h0);
    chk("rstw_pc4", u_if.pc_plus_4_f_o, 32'h4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      u_if.stall_f_i     = ($urandom % 3) == 0;
      u_if.redirect_i    = ($urandom % 12) == 0;
      u_if.redirect_pc_i = $urandom;
      u_if.imem_gnt_i    = ($urandom % 2) == 0;
      u_if.imem_rvalid_i = pend.size() != 0 ? ($urandom % 3) != 0 : ($urandom % 8) == 0;
      u_if.imem_rdata_i  = $urandom;
      cycle();
    end
    idle();
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
